// File: rtl/flash_burst_reader.sv
// flash_burst_reader: read-only controller for a 16-bit parallel NOR flash.
// Assembles BUS_DW-bit words from consecutive FLASH_DW-bit halfwords
// (little-endian), supports single/burst word reads with a fixed access wait.
// Optional one-entry read cache enabled by defining FLASH_READ_CACHE_EN.
module flash_burst_reader #(
    parameter  int ADDR_W      = 22,
    parameter  int BUS_DW      = 32,
    parameter  int FLASH_DW    = 16,
    parameter  int WAIT_CYCLES = 3,
    parameter  int BURST_MAX   = 4,
    localparam int HALVES      = BUS_DW / FLASH_DW,
    localparam int HB          = $clog2(HALVES),
    localparam int LEN_W       = $clog2(BURST_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    bus_addr,
    input  logic [LEN_W-1:0]     bus_len,
    input  logic                 read_op,
    output logic                 bus_busy,
    output logic                 bus_valid,
    output logic [BUS_DW-1:0]    bus_data,
    output logic [ADDR_W+HB-1:0] flash_a,
    input  logic [FLASH_DW-1:0]  flash_d_in,
    output logic                 flash_ce_n,
    output logic                 flash_oe_n,
    output logic                 flash_we_n,
    output logic                 flash_rp_n,
    output logic                 flash_byte_n
);

    localparam int HALF_W = (HB > 0) ? HB : 1;
    localparam int WC_W   = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_DONE, S_HIT
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   word_addr;
    logic [HALF_W-1:0]   half;
    logic [LEN_W-1:0]    words_left;
    logic [LEN_W-1:0]    eff_len;
    logic [WC_W-1:0]     wait_cnt;
    logic [BUS_DW-1:0]   asm_q;
    logic [BUS_DW-1:0]   asm_nx;
    logic [BUS_DW-1:0]   cache_rd;
    logic                accept;
    logic                hit;
    logic                last_half;
    logic                last_word;
    logic                strobe_nx;

    assign flash_we_n   = 1'b1;
    assign flash_rp_n   = 1'b1;
    assign flash_byte_n = 1'b1;

    generate
        if (HB == 0) begin : g_single_half
            assign flash_a = word_addr;
        end else begin : g_multi_half
            assign flash_a = {word_addr, half};
        end
    endgenerate

    // Effective length: zero means one word, oversize clamps to BURST_MAX
    always_comb begin
        eff_len = bus_len;
        if (bus_len == '0)
            eff_len = LEN_W'(1);
        else if (bus_len > LEN_W'(BURST_MAX))
            eff_len = LEN_W'(BURST_MAX);
    end

    assign last_half = (half == HALF_W'(HALVES - 1));
    assign last_word = (words_left == LEN_W'(1));

    // Merge the halfword on the flash bus into the word being assembled
    always_comb begin
        asm_nx = asm_q;
        asm_nx[half*FLASH_DW +: FLASH_DW] = flash_d_in;
    end

`ifdef FLASH_READ_CACHE_EN
    logic [ADDR_W-1:0] cache_tag;
    logic [BUS_DW-1:0] cache_data;
    logic              cache_valid;

    assign hit      = cache_valid && (eff_len == LEN_W'(1)) && (cache_tag == bus_addr);
    assign cache_rd = cache_data;

    // Remember the most recently delivered flash word and its address
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (state == S_LATCH && last_half) begin
            cache_valid <= 1'b1;
            cache_tag   <= word_addr;
            cache_data  <= asm_nx;
        end
    end
`else
    assign hit      = 1'b0;
    assign cache_rd = '0;
`endif

    // Next-state and combinational outputs
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        bus_busy  = 1'b0;
        strobe_nx = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                accept   = read_op;
                state_nx = read_op ? (hit ? S_HIT : S_ADDR) : S_IDLE;
            end
            S_ADDR: begin
                bus_busy = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                bus_busy = 1'b1;
                if (wait_cnt == '0)
                    state_nx = S_LATCH;
            end
            S_LATCH: begin
                bus_busy = 1'b1;
                state_nx = (!last_half || !last_word) ? S_ADDR : S_DONE;
            end
            S_HIT: begin
                bus_busy = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        strobe_nx = (state_nx == S_ADDR) || (state_nx == S_WAIT) || (state_nx == S_LATCH);
    end

    // State register and registered flash strobes (low for the whole access)
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
        end else begin
            state      <= state_nx;
            flash_ce_n <= ~strobe_nx;
            flash_oe_n <= ~strobe_nx;
        end
    end

    // Address/length counters, halfword assembly and word delivery
    always_ff @(posedge clk) begin
        if (rst) begin
            word_addr  <= '0;
            half       <= '0;
            words_left <= '0;
            wait_cnt   <= '0;
            asm_q      <= '0;
            bus_data   <= '0;
            bus_valid  <= 1'b0;
        end else begin
            bus_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (hit) begin
                            bus_valid <= 1'b1;
                            bus_data  <= cache_rd;
                        end else begin
                            word_addr  <= bus_addr;
                            half       <= '0;
                            words_left <= eff_len;
                        end
                    end
                end
                S_ADDR: wait_cnt <= WC_W'(WAIT_CYCLES - 1);
                S_WAIT: begin
                    if (wait_cnt != '0)
                        wait_cnt <= wait_cnt - WC_W'(1);
                end
                S_LATCH: begin
                    asm_q <= asm_nx;
                    if (!last_half) begin
                        half <= half + HALF_W'(1);
                    end else begin
                        bus_valid  <= 1'b1;
                        bus_data   <= asm_nx;
                        words_left <= words_left - LEN_W'(1);
                        if (!last_word) begin
                            word_addr <= word_addr + ADDR_W'(1);
                            half      <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_burst_reader.sv
// Self-checking bench for flash_burst_reader (default parameters).
// Reference model: per request, the expected word list, delivery cycles,
// halfword address sequence and strobe/busy cycle counts are derived from
// the request with plain arithmetic; an optional cache model tracks tag/valid.
module tb_flash_burst_reader;

    localparam int WAITC = 3;

`ifdef FLASH_READ_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        read_op;
    logic [21:0] bus_addr;
    logic [2:0]  bus_len;
    logic        bus_busy;
    logic        bus_valid;
    logic [31:0] bus_data;
    logic [22:0] flash_a;
    logic [15:0] flash_d_in = 16'h0;
    logic        flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n, flash_byte_n;

    flash_burst_reader #(
        .ADDR_W(22), .BUS_DW(32), .FLASH_DW(16), .WAIT_CYCLES(WAITC), .BURST_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_len(bus_len),
        .read_op(read_op), .bus_busy(bus_busy), .bus_valid(bus_valid),
        .bus_data(bus_data), .flash_a(flash_a), .flash_d_in(flash_d_in),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
        .flash_rp_n(flash_rp_n), .flash_byte_n(flash_byte_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash model and bus/pin monitor, evaluated mid-cycle
    int          fcnt = 0;
    logic [22:0] prev_a = '0;
    logic [22:0] alog[$];
    int          vcyc[$];
    logic [31:0] vdat[$];
    int          ce_low = 0;
    int          busy_hi = 0;

    always @(negedge clk) begin
        if (flash_ce_n || flash_oe_n) fcnt = 0;
        else if (flash_a != prev_a)   fcnt = 1;
        else                          fcnt = fcnt + 1;
        prev_a = flash_a;
        if (fcnt == 1) alog.push_back(flash_a);
        if (!flash_ce_n) ce_low++;
        if (bus_busy) busy_hi++;
        if (bus_valid) begin
            vcyc.push_back(cyc);
            vdat.push_back(bus_data);
        end
        // Data only becomes valid once the address has been held for the access time
        flash_d_in = (fcnt >= WAITC + 2) ? (flash_a[15:0] ^ 16'hA5A5) : 16'hDEAD;
    end

    int          n_assert = 0;
    int          n_fail = 0;
    bit          c_valid = 1'b0;
    logic [21:0] c_tag = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [21:0] w);
        logic [15:0] lo, hi;
        lo = {w[14:0], 1'b0} ^ 16'hA5A5;
        hi = {w[14:0], 1'b1} ^ 16'hA5A5;
        return {hi, lo};
    endfunction

    task automatic clear_mon();
        alog.delete();
        vcyc.delete();
        vdat.delete();
        ce_low = 0;
        busy_hi = 0;
    endtask

    // One request; poke_at >= 0 issues a stray read_op that many cycles into the burst
    task automatic run_req(input logic [21:0] addr, input logic [2:0] len, input int poke_at);
        int          n, acc, nv;
        bit          hit;
        logic [21:0] w;
        n   = (len == 3'd0) ? 1 : (len > 3'd4) ? 4 : int'(len);
        hit = CACHE_EN && c_valid && (n == 1) && (c_tag == addr);
        nv  = n;
        @(negedge clk); #2;
        clear_mon();
        check("busy_before", 64'(bus_busy), 64'd0);
        read_op  = 1'b1;
        bus_addr = addr;
        bus_len  = len;
        @(posedge clk); #1;
        acc      = cyc;
        read_op  = 1'b0;
        bus_addr = 22'($urandom);
        bus_len  = 3'($urandom_range(0, 7));
        for (int k = 0; k < 10 * n + 5; k++) begin
            @(negedge clk); #2;
            if (k == poke_at) begin
                read_op  = 1'b1;
                bus_addr = 22'($urandom);
            end else begin
                read_op = 1'b0;
            end
        end
        read_op = 1'b0;
        check("valid_count", 64'(vcyc.size()), 64'(nv));
        for (int i = 0; i < nv; i++) begin
            w = addr + 22'(i);
            if (i < vcyc.size()) begin
                check("latency", 64'(vcyc[i] - acc), hit ? 64'd0 : 64'(10 * (i + 1)));
                check("data", 64'(vdat[i]), 64'(exp_word(w)));
            end
        end
        check("addr_count", 64'(alog.size()), hit ? 64'd0 : 64'(2 * n));
        if (!hit) begin
            for (int i = 0; i < 2 * n; i++) begin
                w = addr + 22'(i / 2);
                if (i < alog.size())
                    check("flash_a", 64'(alog[i]), 64'({w, 1'(i % 2)}));
            end
        end
        check("ce_low_cycles", 64'(ce_low), hit ? 64'd0 : 64'(10 * n));
        check("busy_cycles", 64'(busy_hi), hit ? 64'd1 : 64'(10 * n));
        check("busy_after", 64'(bus_busy), 64'd0);
        if (!hit) begin
            c_valid = 1'b1;
            c_tag   = addr + 22'(n - 1);
        end
    endtask

    initial begin
        int          acc;
        logic [21:0] last_addr;
        rst      = 1'b1;
        read_op  = 1'b0;
        bus_addr = '0;
        bus_len  = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #2;
            check("rst_ce_n", 64'(flash_ce_n), 64'd1);
        end
        check("rst_busy", 64'(bus_busy), 64'd0);
        check("rst_valid", 64'(bus_valid), 64'd0);
        check("rst_data", 64'(bus_data), 64'd0);
        check("rst_flash_a", 64'(flash_a), 64'd0);
        check("rst_oe_n", 64'(flash_oe_n), 64'd1);
        check("rst_ties", 64'({flash_we_n, flash_rp_n, flash_byte_n}), 64'h7);
        rst = 1'b0;
        c_valid = 1'b0;

        // Single read of word 0x10
        run_req(22'h000010, 3'd1, -1);
        if (vdat.size() > 0) check("known_word", 64'(vdat[0]), 64'hA584A585);

        // Repeat read: cache hit when enabled, full access otherwise
        run_req(22'h000010, 3'd1, -1);

        // Burst wrapping past the top of the address space
        run_req(22'h3FFFFE, 3'd4, -1);

        // Length edges
        run_req(22'($urandom), 3'd0, -1);
        run_req(22'($urandom), 3'd7, -1);

        // Stray read_op during a burst is ignored
        run_req(22'($urandom), 3'd4, 15);

        // Reset during WAIT of the second word of a 4-word burst
        @(negedge clk); #2;
        clear_mon();
        read_op  = 1'b1;
        bus_addr = 22'h0001A0;
        bus_len  = 3'd4;
        @(posedge clk); #1;
        acc     = cyc;
        read_op = 1'b0;
        while (cyc < acc + 12) @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        c_valid = 1'b0;
        @(negedge clk); #2;
        check("abort_ce_n", 64'(flash_ce_n), 64'd1);
        check("abort_oe_n", 64'(flash_oe_n), 64'd1);
        check("abort_busy", 64'(bus_busy), 64'd0);
        check("abort_data", 64'(bus_data), 64'd0);
        repeat (40) @(negedge clk);
        #2;
        check("abort_valids", 64'(vcyc.size()), 64'd1);

        // Reads after the abort; first repeat of a pre-reset address must miss
        run_req(22'h000010, 3'd1, -1);
        run_req(22'h000010, 3'd1, -1);

        // Randomised requests, every other one reusing the previous address
        last_addr = 22'h000010;
        for (int i = 0; i < 8; i++) begin
            logic [21:0] a;
            a = (i % 2 == 1) ? last_addr : 22'($urandom);
            run_req(a, 3'($urandom_range(0, 7)), -1);
            last_addr = a;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
